// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-stage valid/ready pipeline register with flush and NOP bubbles; optional stall counter under PIPE_STALL_CNT_EN
module pipe_stage_elastic #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int DEPTH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);
  localparam int OW = $clog2(DEPTH+1);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_elastic: DEPTH must be in 1..4");
  end
  logic [DEPTH-1:0]  r_v, w_adv, w_sv, w_vn;
  logic [CTRL_W-1:0] r_ctrl [DEPTH];
  logic [CTRL_W-1:0] w_sc   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] w_sd   [DEPTH];
  logic [OW-1:0]     r_occ, w_cnt;
  assign in_ready  = w_adv[0] && !flush;
  assign w_sv[0]   = in_valid && in_ready;
  assign w_sc[0]   = in_ctrl;
  assign w_sd[0]   = in_data;
  assign out_valid = r_v[DEPTH-1];
  assign out_ctrl  = r_ctrl[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign w_adv[g] = out_ready || ((r_v >> g) != ({DEPTH{1'b1}} >> g));
    if (g > 0) begin : g_src
      assign w_sv[g] = r_v[g-1];
      assign w_sc[g] = r_ctrl[g-1];
      assign w_sd[g] = r_data[g-1];
    end
  end
  // next valid per stage and the resulting occupancy
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_vn[i] = !flush && (w_adv[i] ? w_sv[i] : r_v[i]);
      w_cnt   = w_cnt + OW'(w_vn[i]);
    end
  end
  // stage registers: bubbles and flushes zero ctrl, data follows real bundles only
  always_ff @(posedge clk) begin
    r_v   <= rst ? '0 : w_vn;
    r_occ <= rst ? '0 : w_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_ctrl[i] <= '0;
        r_data[i] <= '0;
      end else begin
        r_ctrl[i] <= w_vn[i] ? (w_adv[i] ? w_sc[i] : r_ctrl[i]) : '0;
        if (w_vn[i] && w_adv[i]) r_data[i] <= w_sd[i];
      end
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] r_stall;
  // saturating count of backpressured output cycles, cleared only by reset
  always_ff @(posedge clk)
    r_stall <= rst ? '0 : r_stall + 16'(out_valid && !out_ready && r_stall != 16'hFFFF);
  assign stall_cnt = r_stall;
`endif
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline register for the core datapath. It carries a control bundle and a data bundle through DEPTH register stages, using a valid/ready handshake, with stall (backpressure) and flush support. On flush or drain it inserts bubbles whose control fields are zero, so a bubble reads as a NOP downstream. It sits between any two pipeline stages (decode→execute, execute→memory, …) and replaces the fixed single-stage, always-advancing stage registers.

## Interface
Parameters:
- CTRL_W, 16: control bundle width; zeroed on reset, flush and bubble.
- DATA_W, 160: data bundle width (operands, PCs, immediates, register indices); zeroed only on reset.
- DEPTH, 1: number of register stages, legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage 0 can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of every in-flight bundle (branch mispredict / redirect).
- out_valid  out  1  last stage holds a valid bundle.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  last-stage control; 0 whenever out_valid=0.
- out_data  out  DATA_W  last-stage data.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.
- stall_cnt  out  16  backpressure cycle counter; present only with PIPE_STALL_CNT_EN.

## Operation
- Each stage i holds v[i], ctrl[i], data[i]. Stage DEPTH-1 drives the out_* ports.
- Advance chain: adv[DEPTH-1] = !v[DEPTH-1] || out_ready. For i < DEPTH-1, adv[i] = !v[i] || adv[i+1]. in_ready = adv[0] && !flush.
- When adv[i] is true, stage i loads the contents of stage i-1 (stage 0 loads the in_* inputs, with valid = in_valid && in_ready).
- If the loaded valid is 0, ctrl[i] is loaded as 0 and data[i] holds its previous value.
- When adv[i] is false, stage i holds all of its fields.
- A handshake occurs on in_valid && in_ready (input side) and on out_valid && out_ready (output side).
- flush=1: at the next edge every v[i] becomes 0 and every ctrl[i] becomes 0, data is unchanged, and no input is captured. in_ready is 0 during the flush cycle.
- rst has priority over flush and over the handshake: all v, ctrl and data become 0.
- occupancy equals the sum of v[i], registered alongside v.
- Bundles are never dropped, duplicated or reordered except by flush or rst.
- DEPTH outside 1..4 raises an elaboration-time error.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0. in_ready=1 in the first cycle after reset (if flush=0).
- Latency: a bundle accepted at edge k is presented on out_* after edge k+DEPTH-1, i.e. visible DEPTH cycles after it was presented on in_*, provided there is no backpressure.
- Throughput: 1 bundle/cycle with out_ready held high. in_ready depends combinationally on out_ready through the adv chain. There is no path from in_valid to in_ready.
- Full: all v=1 and out_ready=0, so in_ready=0 and everything holds. When out_ready returns to 1, in_ready=1 in the same cycle, so a full pipeline accepts and emits on the same edge.
- Empty: out_valid=0 and out_ctrl=0, regardless of in_valid, until DEPTH edges after an accept.
- A simultaneous output handshake and flush counts as consumed, and the bundle is gone after the edge.

## Configuration
- PIPE_STALL_CNT_EN defined:
  - stall_cnt is present and increments by 1 each cycle with out_valid=1 && out_ready=0.
  - It saturates at 16'hFFFF and is cleared only by rst; flush does not clear it.
- PIPE_STALL_CNT_EN undefined: the stall_cnt port and its logic are absent, and all other behaviour is identical.

## Test plan
- DEPTH=1, out_ready=1, stream in_ctrl=1..5 on consecutive cycles → out_ctrl=1..5 on consecutive cycles, each one cycle after input, with occupancy=1 throughout.
- DEPTH=3, hold out_ready=0 and offer 4 bundles → exactly 3 accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready → in order out A,B,C, then D is accepted in the same cycle out_ready rises.
- DEPTH=3, occupancy=2, assert flush for 1 cycle while in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, data unchanged, flush-cycle input not seen at output.
- Assert rst mid-stream (DEPTH=2, occupancy=2) while flush=1 → next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 once flush drops.
- DEPTH=2, single bundle then idle → out_valid high for exactly 1 cycle; afterwards out_ctrl=0 and out_data holds the bundle's data.
- With PIPE_STALL_CNT_EN: out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF. A flush leaves it at 16'hFFFF; rst gives 0.
